sin_taylor_seq: RTL and testbench
=================================

Name: sin_taylor_seq

Overview:
- Multi-cycle sequencer that evaluates sin(x) by Taylor series on one shared signed multiplier.
- Converts the 12-bit digital phase into the 6-bit analog code.
- Sits between the phase source and the analog output stage of the sin block.
- Uses the term recurrence t(k) = -t(k-1) * x^2 / ((2k)(2k+1)), so no factorial or divide hardware is needed.

Parameters:
- N_TERMS, 5, number of series terms summed (x, x^3, ... up to x^(2N-1)); legal range 2..6.
- FRAC, 16, fractional bits of the internal fixed-point format; internal width W = FRAC+4, signed.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- digital  input  12  phase x, unsigned Q1.11 radians, range [0, 2).
- in_valid  input  1  digital is valid.
- in_ready  output  1  block can accept a phase.
- analog  output  6  sin(x), unsigned Q0.6, saturated.
- out_valid  output  1  analog is valid.
- out_ready  input  1  consumer accepts analog.
- busy  output  1  evaluation in progress.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - state=IDLE; analog=0, out_valid=0, busy=0, in_ready=1.
  - x, x2, term, sum and k all cleared.
- Reset mid-evaluation aborts immediately. No output is produced for the aborted phase.
- States: IDLE, SQUARE, MULX2, MULRC, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: x=digital<<(FRAC-11), term=x, sum=x, k=1; go to SQUARE.
- SQUARE: x2 = (x*x)>>>FRAC; go to MULX2.
- MULX2: term = (term*x2)>>>FRAC; go to MULRC.
- MULRC: term = (term*RECIP[k])>>>FRAC, where RECIP[k] = round(2^FRAC/((2k)(2k+1))); go to ACC.
- ACC:
  - sum = sum - term if k is odd, sum + term if k is even.
  - If k==N_TERMS-1: load analog, go to DONE. Otherwise k=k+1, go to MULX2.
- DONE:
  - out_valid=1; analog held stable.
  - When out_ready=1: out_valid drops next cycle, go to IDLE.
  - in_valid is ignored in DONE (in_ready=0).
- Control outputs:
  - in_ready=1 only in IDLE.
  - busy=1 in every state except IDLE.
- Latency:
  - Accept edge to out_valid high = 2+3*(N_TERMS-1) cycles (14 for the default).
  - If out_ready is held high, the minimum accept-to-accept interval is latency+1 (15). There is no overlap between evaluations.
- Multiply rules:
  - W×W to 2W signed product, arithmetic shift right by FRAC (truncation toward -inf), then truncate to W.
  - No intermediate saturation; W=FRAC+4 covers x2<4 and |term|<2.
- Output conversion, evaluated in ACC on the final term:
  - sum<0 gives 0.
  - sum>=1.0 gives 63.
  - Otherwise sum[FRAC-1:FRAC-6] (truncate).
- Back-pressure: analog and out_valid are held indefinitely while out_ready=0.
- A change in digital after acceptance has no effect on the running evaluation.

Decomposition:
- Package sin_seq_pkg holds:
  - state enum;
  - FRAC default and W derivation;
  - RECIP constant function/ROM for k=1..5 (1/6, 1/20, 1/42, 1/72, 1/110 in Q0.FRAC);
  - the saturating Q-to-analog conversion function.
- Natural sub-module: sin_seq_mul, the shared registered signed multiply-and-shift. Its operand muxes are driven by the FSM.
- The controller holds the FSM, the k counter and the x/x2/term/sum registers.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then released -> analog=0, out_valid=0, busy=0, in_ready=1. Apply digital=0x000 with in_valid -> analog=0, out_valid exactly 14 cycles after accept.
- Reference points, out_ready held 1:
  - digital=0x400 (0.5 rad) -> analog=30.
  - digital=0x800 (1.0 rad) -> analog=53.
  - digital=0xFFF (1.9995 rad) -> analog=58.
  - Each at 14-cycle latency; the next accept is possible 15 cycles after the previous one.
- Saturation: digital=0xC91 (≈π/2, series sum >1.0) -> analog=63.
- Back-pressure: digital=0x800 with out_ready=0 for 10 cycles after out_valid -> analog=53 and out_valid stay high and stable. in_ready=0 throughout, and a second in_valid pulse is not accepted. out_ready=1 -> IDLE next cycle.
- Reset mid-evaluation: accept 0x800, assert rst_n low at cycle 6 -> outputs return to reset values immediately and no out_valid follows. Accepting 0x400 after release -> analog=30 at normal latency.
- Parameter sweep: N_TERMS=2 with digital=0x800 -> latency 5, analog=53 (1-1/6=0.833). N_TERMS=6 with digital=0x800 -> latency 17, analog=53.

Source files
------------

// File: rtl/sin_seq_pkg.sv
// Shared types and constants for the Taylor-series sine sequencer.
// Holds the state encoding, fixed-point sizing, reciprocal table builder and output conversion.
package sin_seq_pkg;

    localparam int FRAC_DEF = 16;
    localparam int W_MARGIN = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQUARE,
        S_MULX2,
        S_MULRC,
        S_ACC,
        S_DONE
    } state_t;

    // round(2^frac / ((2k)(2k+1))); only ever evaluated with constant arguments
    function automatic longint recip(input int k, input int frac);
        longint d;
        d = longint'((2 * k) * (2 * k + 1));
        return ((longint'(1) <<< frac) + d / 2) / d;
    endfunction

    // Clamp a signed Q.frac value into the unsigned Q0.6 analog code
    function automatic logic [5:0] to_analog(input longint s, input int frac);
        if (s < 0) begin
            return 6'd0;
        end
        if (s >= (longint'(1) <<< frac)) begin
            return 6'd63;
        end
        return 6'(s >>> (frac - 6));
    endfunction

endpackage

// File: rtl/sin_seq_mul.sv
// Shared signed fixed-point multiplier: full-width product, arithmetic shift by FRAC, wrap to W.
// The controller registers the result into whichever operand register the current state owns.
module sin_seq_mul
    import sin_seq_pkg::*;
#(
    parameter int FRAC = FRAC_DEF,
    parameter int W    = FRAC_DEF + W_MARGIN
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] p
);

    logic signed [2*W-1:0] prod;

    assign prod = (2*W)'(a) * (2*W)'(b);
    assign p    = W'(prod >>> FRAC);

endmodule

// File: rtl/sin_taylor_seq.sv
// Multi-cycle sin(x) evaluator: sums N_TERMS Taylor terms using t(k) = -t(k-1)*x^2/((2k)(2k+1))
// on one shared multiplier, then saturates the sum into a 6-bit analog code.
module sin_taylor_seq
    import sin_seq_pkg::*;
#(
    parameter int N_TERMS = 5,
    parameter int FRAC    = FRAC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] digital,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [5:0]  analog,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam int W = FRAC + W_MARGIN;
    localparam logic [2:0] K_LAST = 3'(N_TERMS - 1);

    // Index 0, 6 and 7 are never selected; k runs 1..N_TERMS-1
    localparam logic signed [W-1:0] RECIP [8] = '{
        '0,
        W'(recip(1, FRAC)),
        W'(recip(2, FRAC)),
        W'(recip(3, FRAC)),
        W'(recip(4, FRAC)),
        W'(recip(5, FRAC)),
        '0,
        '0
    };

    state_t state;
    state_t state_next;

    logic signed [W-1:0] x;
    logic signed [W-1:0] x2;
    logic signed [W-1:0] term;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] sum_next;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] mul_a;
    logic signed [W-1:0] mul_b;
    logic signed [W-1:0] mul_p;
    logic [2:0]          k;
    logic [5:0]          analog_q;

    // Q1.11 phase aligned to the Q.FRAC grid, always non-negative
    assign x_in     = W'({digital, {(FRAC - 11){1'b0}}});
    assign sum_next = k[0] ? (sum - term) : (sum + term);
    assign analog   = analog_q;

    sin_seq_mul #(
        .FRAC (FRAC),
        .W    (W)
    ) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (in_valid) state_next = S_SQUARE;
            S_SQUARE: state_next = S_MULX2;
            S_MULX2:  state_next = S_MULRC;
            S_MULRC:  state_next = S_ACC;
            S_ACC:    state_next = (k == K_LAST) ? S_DONE : S_MULX2;
            S_DONE:   if (out_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state != S_IDLE);
        out_valid = (state == S_DONE);
    end

    always_comb begin
        mul_a = term;
        mul_b = x2;
        case (state)
            S_SQUARE: begin
                mul_a = x;
                mul_b = x;
            end
            S_MULRC:  mul_b = RECIP[k];
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            x2       <= '0;
            term     <= '0;
            sum      <= '0;
            k        <= '0;
            analog_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x    <= x_in;
                        term <= x_in;
                        sum  <= x_in;
                        k    <= 3'd1;
                    end
                end
                S_SQUARE: x2   <= mul_p;
                S_MULX2:  term <= mul_p;
                S_MULRC:  term <= mul_p;
                S_ACC: begin
                    sum <= sum_next;
                    if (k == K_LAST) begin
                        analog_q <= to_analog(longint'(sum_next), FRAC);
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sin_taylor_seq.sv
// Bench for sin_taylor_seq: directed reference phases, back-pressure, mid-evaluation reset,
// randomized phases against a plain-arithmetic series model, and a N_TERMS sweep.
module tb_sin_taylor_seq;

    localparam int FRAC = 16;
    localparam int W    = FRAC + 4;
    localparam int LAT  = 2 + 3 * (5 - 1);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] digital;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  analog;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        fixed_ready;
    logic        rnd_ready;
    logic        rand_bp;

    logic [11:0] sw_digital;
    logic        sw_valid;
    logic        sw_ready;
    logic        d2_in_ready, d2_out_valid, d2_busy;
    logic [5:0]  d2_analog;
    logic        d6_in_ready, d6_out_valid, d6_busy;
    logic [5:0]  d6_analog;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [5:0]  exp_q[$];
    int          acc_q[$];
    bit          seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign out_ready = rand_bp ? rnd_ready : fixed_ready;

    always @(negedge clk) rnd_ready = ($urandom_range(0, 3) != 0);

    sin_taylor_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digital   (digital),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .analog    (analog),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    sin_taylor_seq #(.N_TERMS(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .digital   (sw_digital),
        .in_valid  (sw_valid),
        .in_ready  (d2_in_ready),
        .analog    (d2_analog),
        .out_valid (d2_out_valid),
        .out_ready (sw_ready),
        .busy      (d2_busy)
    );

    sin_taylor_seq #(.N_TERMS(6)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .digital   (sw_digital),
        .in_valid  (sw_valid),
        .in_ready  (d6_in_ready),
        .analog    (d6_analog),
        .out_valid (d6_out_valid),
        .out_ready (sw_ready),
        .busy      (d6_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Signed Q.FRAC product, floored, wrapped into W bits
    function automatic longint mulq(input longint a, input longint b);
        longint p;
        logic signed [W-1:0] r;
        p = (a * b) >>> FRAC;
        r = W'(p);
        return longint'(r);
    endfunction

    // Series model: partial Taylor sum with real-valued reciprocals rounded to Q.FRAC
    function automatic logic [5:0] model(input int d, input int n);
        longint one, x, x2, t, s, rc;
        one = longint'(1) <<< FRAC;
        x   = longint'(d) * (one / 2048);
        x2  = mulq(x, x);
        t   = x;
        s   = x;
        for (int kk = 1; kk < n; kk++) begin
            rc = longint'($rtoi(real'(one) / real'((2 * kk) * (2 * kk + 1)) + 0.5));
            t  = mulq(mulq(t, x2), rc);
            s  = (kk % 2 == 1) ? s - t : s + t;
        end
        if (s < 0) return 6'd0;
        if (s >= one) return 6'd63;
        return 6'(s / (one / 64));
    endfunction

    // Driver: hold a phase until accepted; afterwards scramble digital
    task automatic send(input logic [11:0] d, input logic [5:0] e, input bit push, output int acc);
        int guard;
        guard    = 0;
        acc      = -1;
        digital  = d;
        in_valid = 1'b1;
        while (!in_ready) begin
            if (guard > 200) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        acc      = cyc;
        in_valid = 1'b0;
        digital  = 12'($urandom_range(0, 4095));
        if (push) begin
            exp_q.push_back(e);
            acc_q.push_back(acc);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", int'(guard >= 2000), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_analog"}, analog, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    // Monitor: compare the first cycle of every presented result against the queue
    always @(negedge clk) begin
        logic [5:0] e;
        int a;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_output", analog, -1);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("analog", analog, e);
                check("latency", cyc - a + 1, LAT);
            end
        end else if (!out_valid) begin
            seen = 1'b0;
        end
    end

    initial begin
        #400us;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] d_tab [4];
        logic [5:0]  e_tab [4];
        int acc, prev, guard, start, lat2, lat6;
        logic [11:0] d;

        d_tab = '{12'h400, 12'h800, 12'hFFF, 12'hC91};
        e_tab = '{6'd30, 6'd53, 6'd58, 6'd63};

        rst_n       = 1'b0;
        digital     = '0;
        in_valid    = 1'b0;
        fixed_ready = 1'b1;
        rand_bp     = 1'b0;
        sw_digital  = '0;
        sw_valid    = 1'b0;
        sw_ready    = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");

        send(12'h000, 6'd0, 1'b1, acc);
        drain();

        // Reference phases issued back to back
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            send(d_tab[i], e_tab[i], 1'b1, acc);
            if (prev >= 0) check("accept_interval", acc - prev, LAT + 1);
            prev = acc;
        end
        drain();

        // Back-pressure with a stray request while the result waits
        fixed_ready = 1'b0;
        send(12'h800, 6'd53, 1'b1, acc);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("bp_out_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            digital  = 12'h123;
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_analog", analog, 53);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid    = 1'b0;
        fixed_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_busy", busy, 0);
        repeat (20) @(negedge clk);

        // Abort an evaluation with reset; no result may follow
        send(12'h800, 6'd0, 1'b0, acc);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_output", out_valid, 0);
        send(12'h400, 6'd30, 1'b1, acc);
        drain();

        // Randomized phases with random consumer stalls
        rand_bp = 1'b1;
        for (int i = 0; i < 25; i++) begin
            d = 12'($urandom_range(0, 4095));
            send(d, model(int'(d), 5), 1'b1, acc);
        end
        drain();
        rand_bp = 1'b0;
        repeat (3) @(negedge clk);

        // Series length sweep on the extra instances
        check("sweep2_idle", d2_in_ready, 1);
        check("sweep6_idle", d6_in_ready, 1);
        sw_digital = 12'h800;
        sw_valid   = 1'b1;
        @(negedge clk);
        sw_valid   = 1'b0;
        start      = cyc;
        lat2       = -1;
        lat6       = -1;
        for (int i = 0; i < 40; i++) begin
            if (d2_out_valid && lat2 < 0) begin
                lat2 = cyc - start + 1;
                check("sweep2_analog", d2_analog, 53);
            end
            if (d6_out_valid && lat6 < 0) begin
                lat6 = cyc - start + 1;
                check("sweep6_analog", d6_analog, 53);
            end
            @(negedge clk);
        end
        check("sweep2_latency", lat2, 5);
        check("sweep6_latency", lat6, 17);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
